// File: rtl/audio_pkg.sv
// Shared constants and state encoding for the I2S DAC sequencer and serialiser.
package audio_pkg;

  localparam int unsigned SLOT_BITS        = 32;
  localparam int unsigned FRAME_BITS       = 64;
  localparam int unsigned SAMPLE_W_DEFAULT = 24;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHeld,
    StWait
  } seq_state_e;

endpackage

// File: rtl/audio_clk_div.sv
// BCLK/LRCK generator: divides the system clock to BCLK and counts BCLK periods in a frame.
module audio_clk_div import audio_pkg::*; #(
  parameter int unsigned BCLK_HALF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       bclk,
  output logic       lrck,
  output logic       bclk_fall,
  output logic       frame_start,
  output logic [5:0] bit_cnt
);

  localparam int unsigned DivW = $clog2(BCLK_HALF);

  logic [DivW-1:0] div_q, div_d;
  logic            bclk_q, bclk_d;
  logic [5:0]      bit_q, bit_d;
  logic            wrap;

  always_comb begin
    wrap        = (div_q == DivW'(BCLK_HALF - 1));
    div_d       = wrap ? '0 : div_q + 1'b1;
    bclk_d      = wrap ? ~bclk_q : bclk_q;
    bclk_fall   = en && wrap && bclk_q;
    bit_d       = bclk_fall ? bit_q + 6'd1 : bit_q;
    frame_start = bclk_fall && (bit_q == 6'(FRAME_BITS - 1));
    // Disabled: clocks parked low and the frame restarts from bit 0.
    if (!en) begin
      div_d  = '0;
      bclk_d = 1'b0;
      bit_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
      bit_q  <= '0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
      bit_q  <= bit_d;
    end
  end

  assign bclk    = bclk_q;
  assign lrck    = bit_q[$clog2(SLOT_BITS)];
  assign bit_cnt = bit_q;

endmodule

// File: rtl/audio_i2s_sequencer.sv
// I2S DAC sequencer: frame timing, per-frame sample request handshake and held output pair.
module audio_i2s_sequencer import audio_pkg::*; #(
  parameter int unsigned BCLK_HALF = 4,
  parameter int unsigned SAMPLE_W  = SAMPLE_W_DEFAULT,
  parameter int unsigned UPD_BIT   = 16
) (
  input  logic                iCLK,
  input  logic                reset_reg,
  input  logic                i_enable,
  input  logic                i_mute,
  input  logic [SAMPLE_W-1:0] i_lsample,
  input  logic [SAMPLE_W-1:0] i_rsample,
  input  logic                i_sample_valid,
  output logic                o_sample_req,
  output logic                oAUD_BCLK,
  output logic                oAUD_DACLRCK,
  output logic [SAMPLE_W-1:0] o_lsound_out,
  output logic [SAMPLE_W-1:0] o_rsound_out,
  output logic                o_underrun,
  input  logic                i_clr_underrun,
  output logic [7:0]          o_underrun_cnt
);

  localparam logic [5:0] UpdBit = 6'(UPD_BIT);

  seq_state_e          state_q, state_d;
  logic [SAMPLE_W-1:0] stage_l_q, stage_l_d, stage_r_q, stage_r_d;
  logic [SAMPLE_W-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
  logic                underrun_q, underrun_d;
  logic [7:0]          ucnt_q, ucnt_d;
  logic                run, bclk_fall, frame_start, upd, underrun_evt;
  logic [5:0]          bit_cnt;

  assign run = i_enable && (state_q != StIdle);

  audio_clk_div #(
    .BCLK_HALF (BCLK_HALF)
  ) u_clk_div (
    .clk         (iCLK),
    .rst         (reset_reg),
    .en          (run),
    .bclk        (oAUD_BCLK),
    .lrck        (oAUD_DACLRCK),
    .bclk_fall   (bclk_fall),
    .frame_start (frame_start),
    .bit_cnt     (bit_cnt)
  );

  assign upd = bclk_fall && (bit_cnt == UpdBit);

  always_comb begin
    state_d      = state_q;
    stage_l_d    = stage_l_q;
    stage_r_d    = stage_r_q;
    out_l_d      = out_l_q;
    out_r_d      = out_r_q;
    underrun_d   = underrun_q;
    ucnt_d       = ucnt_q;
    underrun_evt = 1'b0;
    if (!i_enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: state_d = StReq;
        StReq: begin
          if (i_sample_valid) begin
            stage_l_d = i_lsample;
            stage_r_d = i_rsample;
            state_d   = StHeld;
          end
          // Nothing staged in time: repeat the previous pair; a same-cycle capture waits a frame.
          if (upd) begin
            underrun_evt = 1'b1;
            if (i_mute) begin
              out_l_d = '0;
              out_r_d = '0;
            end
          end
        end
        StHeld: begin
          if (upd) begin
            out_l_d = i_mute ? '0 : stage_l_q;
            out_r_d = i_mute ? '0 : stage_r_q;
            state_d = StWait;
          end
        end
        StWait: begin
          if (frame_start) state_d = StReq;
        end
        default: state_d = StIdle;
      endcase
    end
    if (i_clr_underrun) begin
      underrun_d = 1'b0;
      ucnt_d     = '0;
    end else if (underrun_evt) begin
      underrun_d = 1'b1;
      if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (reset_reg) begin
      state_q    <= StIdle;
      stage_l_q  <= '0;
      stage_r_q  <= '0;
      out_l_q    <= '0;
      out_r_q    <= '0;
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      stage_l_q  <= stage_l_d;
      stage_r_q  <= stage_r_d;
      out_l_q    <= out_l_d;
      out_r_q    <= out_r_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
    end
  end

  assign o_sample_req   = (state_q == StReq);
  assign o_lsound_out   = out_l_q;
  assign o_rsound_out   = out_r_q;
  assign o_underrun     = underrun_q;
  assign o_underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_audio_i2s_sequencer.sv
// Randomized bench for audio_i2s_sequencer against a frame-timing and handshake reference model.
module tb_audio_i2s_sequencer;

  localparam int unsigned BH    = 2;
  localparam int unsigned SW    = 24;
  localparam int unsigned UPD   = 16;
  localparam int unsigned FRAME = 2 * BH * 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, mute, valid, clr;
  logic [SW-1:0] lin, rin;
  logic          req, bclk, lrck, ur;
  logic [SW-1:0] lout, rout;
  logic [7:0]    ucnt;

  audio_i2s_sequencer #(
    .BCLK_HALF (BH),
    .SAMPLE_W  (SW),
    .UPD_BIT   (UPD)
  ) dut (
    .iCLK           (clk),
    .reset_reg      (rst),
    .i_enable       (en),
    .i_mute         (mute),
    .i_lsample      (lin),
    .i_rsample      (rin),
    .i_sample_valid (valid),
    .o_sample_req   (req),
    .oAUD_BCLK      (bclk),
    .oAUD_DACLRCK   (lrck),
    .o_lsound_out   (lout),
    .o_rsound_out   (rout),
    .o_underrun     (ur),
    .i_clr_underrun (clr),
    .o_underrun_cnt (ucnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: t is the index of the current cycle since the sequencer left idle.
  bit                 active = 0;
  int                 t = 0;
  bit                 m_req = 0, m_waitfs = 0, m_flag = 0;
  int                 m_cnt = 0;
  logic [SW-1:0]      m_l = '0, m_r = '0;
  logic [2*SW-1:0]    staged[$];

  // Source behaviour.
  bit                 starve = 0, fix_data = 0, lat_rand = 0;
  int                 lat = 10, req_age = 0;
  logic [SW-1:0]      fix_l = '0, fix_r = '0;

  task automatic model_edge();
    bit              upd, fs, had, urev;
    int              bitn;
    logic [2*SW-1:0] p;
    urev = 0;
    if (rst) begin
      active = 0; t = 0; m_req = 0; m_waitfs = 0; staged.delete();
      m_l = '0; m_r = '0; m_flag = 0; m_cnt = 0;
    end else begin
      if (!en) begin
        active = 0; m_req = 0; m_waitfs = 0; staged.delete();
      end else if (!active) begin
        active = 1; t = 0; m_req = 1;
      end else begin
        bitn = (t / (2 * BH)) % 64;
        upd  = (t % (2 * BH) == 2 * BH - 1) && (bitn == UPD);
        fs   = (t % (2 * BH) == 2 * BH - 1) && (bitn == 63);
        had  = staged.size() > 0;
        if (m_req && valid) begin
          staged.push_back({lin, rin});
          m_req = 0;
        end
        if (upd) begin
          if (had) begin
            p = staged.pop_front();
            m_l = mute ? '0 : p[2*SW-1:SW];
            m_r = mute ? '0 : p[SW-1:0];
            m_waitfs = 1;
          end else begin
            urev = 1;
            if (mute) begin m_l = '0; m_r = '0; end
          end
        end
        if (fs && m_waitfs) begin
          m_waitfs = 0;
          m_req = 1;
        end
        t++;
      end
      if (clr) begin
        m_flag = 0; m_cnt = 0;
      end else if (urev) begin
        m_flag = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
  endtask

  task automatic drive();
    valid = 1'b0;
    if (en && active && m_req) begin
      if (!starve && req_age > lat) begin
        valid = 1'b1;
        lin = fix_data ? fix_l : SW'($urandom());
        rin = fix_data ? fix_r : SW'($urandom());
      end
    end else if ($urandom_range(0, 5) == 0) begin
      // Stray valid while no request is open must be ignored.
      valid = 1'b1;
      lin = SW'($urandom());
      rin = SW'($urandom());
    end
  endtask

  task automatic tick();
    logic [31:0] e_bclk, e_lrck;
    model_edge();
    @(posedge clk);
    #1;
    e_bclk = active ? 32'((t / BH) % 2) : 32'd0;
    e_lrck = active ? 32'((t / (2 * BH * 32)) % 2) : 32'd0;
    check_eq("bclk", 32'(bclk), e_bclk);
    check_eq("lrck", 32'(lrck), e_lrck);
    check_eq("req", 32'(req), 32'(m_req));
    check_eq("lout", 32'(lout), 32'(m_l));
    check_eq("rout", 32'(rout), 32'(m_r));
    check_eq("underrun", 32'(ur), 32'(m_flag));
    check_eq("underrun_cnt", 32'(ucnt), 32'(m_cnt));
    if (m_req) begin
      req_age++;
      if (req_age == 1 && lat_rand) lat = $urandom_range(0, 40);
    end else begin
      req_age = 0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      tick();
    end
  endtask

  // 0: frame start, 1: bit 40, 2: a pair staged (HELD).
  task automatic wait_for(input int what, input string tag);
    bit hit;
    hit = 0;
    for (int i = 0; i < 3 * FRAME && !hit; i++) begin
      drive();
      tick();
      case (what)
        0:       hit = active && (t % FRAME == 0);
        1:       hit = active && ((t / (2 * BH)) % 64 == 40);
        default: hit = staged.size() > 0;
      endcase
    end
    check_eq(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    int  rises;
    logic prev_req;
    rst = 1'b1; en = 1'b0; mute = 1'b0; valid = 1'b0; clr = 1'b0; lin = '0; rin = '0;
    run(3);
    check_eq("rst_req", 32'(req), 32'd0);
    check_eq("rst_bclk", 32'(bclk), 32'd0);
    check_eq("rst_lout", 32'(lout), 32'd0);
    check_eq("rst_cnt", 32'(ucnt), 32'd0);

    // First pair offered 10 cycles after the request opens.
    rst = 1'b0; en = 1'b1;
    fix_data = 1; fix_l = 24'h123456; fix_r = 24'hABCDEF; lat = 10; lat_rand = 0;
    run(FRAME);
    check_eq("first_l", 32'(lout), 32'h123456);
    check_eq("first_r", 32'(rout), 32'hABCDEF);
    fix_data = 0; lat_rand = 1;
    run(2 * FRAME);

    // One starved frame, then normal service resumes.
    wait_for(0, "wait_fs_b");
    starve = 1;
    run(FRAME);
    starve = 0;
    run(2 * FRAME);
    check_eq("one_underrun", 32'(ucnt), 32'd1);

    // Long starvation saturates the counter; clear pulse resets it.
    wait_for(0, "wait_fs_c");
    starve = 1;
    run(256 * FRAME);
    check_eq("sat_cnt", 32'(ucnt), 32'd255);
    check_eq("sat_flag", 32'(ur), 32'd1);
    clr = 1'b1;
    run(1);
    clr = 1'b0;
    check_eq("clr_cnt", 32'(ucnt), 32'd0);
    check_eq("clr_flag", 32'(ur), 32'd0);
    starve = 0;
    run(2 * FRAME);

    // Muted full-scale data: zeros out, handshake still once per frame.
    mute = 1'b1; fix_data = 1; fix_l = 24'h7FFFFF; fix_r = 24'h7FFFFF;
    wait_for(0, "wait_fs_d");
    rises = 0;
    prev_req = req;
    for (int i = 0; i < 2 * FRAME; i++) begin
      drive();
      tick();
      if (req && !prev_req) rises++;
      prev_req = req;
    end
    check_eq("mute_l", 32'(lout), 32'd0);
    check_eq("mute_req_rises", 32'(rises), 32'd2);
    mute = 1'b0; fix_data = 0;

    // Disable mid-frame at bit 40, then restart.
    wait_for(1, "wait_bit40");
    en = 1'b0;
    run(1);
    check_eq("dis_bclk", 32'(bclk), 32'd0);
    check_eq("dis_lrck", 32'(lrck), 32'd0);
    check_eq("dis_req", 32'(req), 32'd0);
    run(5);
    en = 1'b1;
    run(2 * FRAME);

    // Random mix of mute, starvation and clear pulses.
    for (int f = 0; f < 6; f++) begin
      starve = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < FRAME; i++) begin
        mute = ($urandom_range(0, 7) == 0);
        clr  = ($urandom_range(0, 499) == 0);
        drive();
        tick();
      end
    end
    starve = 0; mute = 1'b0; clr = 1'b0;

    // Reset while a pair is staged.
    wait_for(2, "wait_held");
    rst = 1'b1;
    run(1);
    check_eq("rst_held_lout", 32'(lout), 32'd0);
    check_eq("rst_held_rout", 32'(rout), 32'd0);
    check_eq("rst_held_req", 32'(req), 32'd0);
    check_eq("rst_held_bclk", 32'(bclk), 32'd0);
    rst = 1'b0;
    run(FRAME);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
